// File: rtl/rs_issue.sv
`default_nettype none
// ============================================================================
// Module   : rs_issue
// Brief    : Reservation station with CDB wakeup, dispatch bypass and
//            single-op-in-flight issue into one functional unit. The finished
//            result is held in an output register until it is accepted.
// Revision : 1.0  initial release
// ============================================================================
module rs_issue #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // dispatch
    input  logic                  disp_valid,
    output logic                  disp_ready,
    input  logic [TAG_WIDTH-1:0]  disp_tag,
    input  logic [DATA_WIDTH-1:0] disp_op0_val,
    input  logic                  disp_op0_rdy,
    input  logic [TAG_WIDTH-1:0]  disp_op0_tag,
    input  logic [DATA_WIDTH-1:0] disp_op1_val,
    input  logic                  disp_op1_rdy,
    input  logic [TAG_WIDTH-1:0]  disp_op1_tag,
    // common data bus snoop
    input  logic                  cdb_valid,
    input  logic [TAG_WIDTH-1:0]  cdb_tag,
    input  logic [DATA_WIDTH-1:0] cdb_data,
    // functional unit
    output logic                  fu_ce,
    input  logic                  fu_idle,
    output logic [DATA_WIDTH-1:0] fu_data_0,
    output logic [DATA_WIDTH-1:0] fu_data_1,
    input  logic                  fu_done,
    input  logic [DATA_WIDTH-1:0] fu_result,
    // result output
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [TAG_WIDTH-1:0]  res_tag,
    output logic [DATA_WIDTH-1:0] res_data,
    // pipeline flush
    input  logic                  flush
);

    localparam int IDX_W = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]      valid_q,   valid_d;
    logic [DEPTH-1:0]      op0_rdy_q, op0_rdy_d;
    logic [DEPTH-1:0]      op1_rdy_q, op1_rdy_d;
    logic [TAG_WIDTH-1:0]  dtag_q    [DEPTH];
    logic [TAG_WIDTH-1:0]  dtag_d    [DEPTH];
    logic [TAG_WIDTH-1:0]  op0_tag_q [DEPTH];
    logic [TAG_WIDTH-1:0]  op0_tag_d [DEPTH];
    logic [TAG_WIDTH-1:0]  op1_tag_q [DEPTH];
    logic [TAG_WIDTH-1:0]  op1_tag_d [DEPTH];
    logic [DATA_WIDTH-1:0] op0_val_q [DEPTH];
    logic [DATA_WIDTH-1:0] op0_val_d [DEPTH];
    logic [DATA_WIDTH-1:0] op1_val_q [DEPTH];
    logic [DATA_WIDTH-1:0] op1_val_d [DEPTH];

    // ------------------------------------------------------------------
    // In-flight / result state
    // ------------------------------------------------------------------
    logic                  inflight_q,     inflight_d;
    logic                  drop_q,         drop_d;
    logic [TAG_WIDTH-1:0]  inflight_tag_q, inflight_tag_d;
    logic                  res_valid_q,    res_valid_d;
    logic [TAG_WIDTH-1:0]  res_tag_q,      res_tag_d;
    logic [DATA_WIDTH-1:0] res_data_q,     res_data_d;

    // ------------------------------------------------------------------
    // Selection signals
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]      eligible;
    logic                  alloc_found;
    logic [IDX_W-1:0]      alloc_idx;
    logic                  issue_found;
    logic [IDX_W-1:0]      issue_idx;
    logic                  do_disp;
    logic                  do_issue;

    // Eligibility looks only at registered readiness, so a wakeup this cycle
    // makes the entry eligible next cycle.
    assign eligible = valid_q & op0_rdy_q & op1_rdy_q;

    // Lowest-index free entry and lowest-index eligible entry (descending
    // scan so the last hit is the lowest index).
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        issue_found = 1'b0;
        issue_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
            if (eligible[i]) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
        end
    end

    // Handshake decisions; flush suppresses both dispatch and issue.
    always_comb begin
        disp_ready = alloc_found;
        do_disp    = disp_valid && alloc_found && !flush;
        do_issue   = issue_found && fu_idle && !inflight_q && !res_valid_q && !flush;
    end

    // FU drive: operands of the selected entry only in the issue cycle.
    always_comb begin
        fu_ce     = do_issue;
        fu_data_0 = '0;
        fu_data_1 = '0;
        if (do_issue) begin
            fu_data_0 = op0_val_q[issue_idx];
            fu_data_1 = op1_val_q[issue_idx];
        end
    end

    assign res_valid = res_valid_q;
    assign res_tag   = res_tag_q;
    assign res_data  = res_data_q;

    // Entry next state: wakeup, issue invalidation, dispatch write, flush.
    always_comb begin
        valid_d   = valid_q;
        op0_rdy_d = op0_rdy_q;
        op1_rdy_d = op1_rdy_q;
        for (int i = 0; i < DEPTH; i++) begin
            dtag_d[i]    = dtag_q[i];
            op0_tag_d[i] = op0_tag_q[i];
            op1_tag_d[i] = op1_tag_q[i];
            op0_val_d[i] = op0_val_q[i];
            op1_val_d[i] = op1_val_q[i];
            if (cdb_valid && valid_q[i] && !op0_rdy_q[i] && (op0_tag_q[i] == cdb_tag)) begin
                op0_rdy_d[i] = 1'b1;
                op0_val_d[i] = cdb_data;
            end
            if (cdb_valid && valid_q[i] && !op1_rdy_q[i] && (op1_tag_q[i] == cdb_tag)) begin
                op1_rdy_d[i] = 1'b1;
                op1_val_d[i] = cdb_data;
            end
        end

        if (do_issue) begin
            valid_d[issue_idx] = 1'b0;
        end

        // The allocated entry is invalid in registered state, so it can never
        // collide with the issued entry or with a wakeup above.
        if (do_disp) begin
            valid_d[alloc_idx]   = 1'b1;
            dtag_d[alloc_idx]    = disp_tag;
            op0_tag_d[alloc_idx] = disp_op0_tag;
            op1_tag_d[alloc_idx] = disp_op1_tag;
            if (!disp_op0_rdy && cdb_valid && (disp_op0_tag == cdb_tag)) begin
                op0_rdy_d[alloc_idx] = 1'b1;
                op0_val_d[alloc_idx] = cdb_data;
            end else begin
                op0_rdy_d[alloc_idx] = disp_op0_rdy;
                op0_val_d[alloc_idx] = disp_op0_val;
            end
            if (!disp_op1_rdy && cdb_valid && (disp_op1_tag == cdb_tag)) begin
                op1_rdy_d[alloc_idx] = 1'b1;
                op1_val_d[alloc_idx] = cdb_data;
            end else begin
                op1_rdy_d[alloc_idx] = disp_op1_rdy;
                op1_val_d[alloc_idx] = disp_op1_val;
            end
        end

        if (flush) begin
            valid_d = '0;
        end
    end

    // In-flight tracking and result register next state.
    always_comb begin
        inflight_d     = inflight_q;
        drop_d         = drop_q;
        inflight_tag_d = inflight_tag_q;
        res_valid_d    = res_valid_q;
        res_tag_d      = res_tag_q;
        res_data_d     = res_data_q;

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        // A completion only matters while something is in flight; a dropped
        // op retires silently.
        if (fu_done && inflight_q) begin
            inflight_d = 1'b0;
            drop_d     = 1'b0;
            if (!drop_q) begin
                res_valid_d = 1'b1;
                res_tag_d   = inflight_tag_q;
                res_data_d  = fu_result;
            end
        end

        if (do_issue) begin
            inflight_d     = 1'b1;
            inflight_tag_d = dtag_q[issue_idx];
        end

        // Flush discards any result. An op still executing is marked for
        // drop; one completing in this very cycle is simply retired above,
        // otherwise we would wait for a second completion that never comes.
        if (flush) begin
            res_valid_d = 1'b0;
            if (inflight_q && !fu_done) begin
                drop_d = 1'b1;
            end
        end
    end

    // Entry state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            op0_rdy_q <= '0;
            op1_rdy_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dtag_q[i]    <= '0;
                op0_tag_q[i] <= '0;
                op1_tag_q[i] <= '0;
                op0_val_q[i] <= '0;
                op1_val_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            op0_rdy_q <= op0_rdy_d;
            op1_rdy_q <= op1_rdy_d;
            for (int i = 0; i < DEPTH; i++) begin
                dtag_q[i]    <= dtag_d[i];
                op0_tag_q[i] <= op0_tag_d[i];
                op1_tag_q[i] <= op1_tag_d[i];
                op0_val_q[i] <= op0_val_d[i];
                op1_val_q[i] <= op1_val_d[i];
            end
        end
    end

    // In-flight and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q     <= 1'b0;
            drop_q         <= 1'b0;
            inflight_tag_q <= '0;
            res_valid_q    <= 1'b0;
            res_tag_q      <= '0;
            res_data_q     <= '0;
        end else begin
            inflight_q     <= inflight_d;
            drop_q         <= drop_d;
            inflight_tag_q <= inflight_tag_d;
            res_valid_q    <= res_valid_d;
            res_tag_q      <= res_tag_d;
            res_data_q     <= res_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_issue
// Brief    : Directed self-checking bench for rs_issue (DEPTH=4, 32-bit data,
//            4-bit tags) with hand-computed expected values.
// Revision : 1.0  initial release
// ============================================================================
module tb_rs_issue;

    localparam int DW = 32;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_valid;
    logic          disp_ready;
    logic [TW-1:0] disp_tag;
    logic [DW-1:0] disp_op0_val;
    logic          disp_op0_rdy;
    logic [TW-1:0] disp_op0_tag;
    logic [DW-1:0] disp_op1_val;
    logic          disp_op1_rdy;
    logic [TW-1:0] disp_op1_tag;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic          fu_ce;
    logic          fu_idle;
    logic [DW-1:0] fu_data_0;
    logic [DW-1:0] fu_data_1;
    logic          fu_done;
    logic [DW-1:0] fu_result;
    logic          res_valid;
    logic          res_ready;
    logic [TW-1:0] res_tag;
    logic [DW-1:0] res_data;
    logic          flush;

    int n_vec = 0;
    int n_err = 0;

    rs_issue #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_tag(disp_tag),
        .disp_op0_val(disp_op0_val), .disp_op0_rdy(disp_op0_rdy), .disp_op0_tag(disp_op0_tag),
        .disp_op1_val(disp_op1_val), .disp_op1_rdy(disp_op1_rdy), .disp_op1_tag(disp_op1_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .fu_ce(fu_ce), .fu_idle(fu_idle), .fu_data_0(fu_data_0), .fu_data_1(fu_data_1),
        .fu_done(fu_done), .fu_result(fu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_data(res_data),
        .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic dispatch(input logic [TW-1:0] t,
                            input logic [DW-1:0] v0, input logic r0, input logic [TW-1:0] t0,
                            input logic [DW-1:0] v1, input logic r1, input logic [TW-1:0] t1);
        disp_valid   = 1'b1;
        disp_tag     = t;
        disp_op0_val = v0;
        disp_op0_rdy = r0;
        disp_op0_tag = t0;
        disp_op1_val = v1;
        disp_op1_rdy = r1;
        disp_op1_tag = t1;
    endtask

    // Called in an issue cycle: let the op issue, return a result one cycle
    // later, check it and accept it.
    task automatic complete(input string name, input logic [DW-1:0] r, input logic [TW-1:0] etag);
        step();
        fu_done   = 1'b1;
        fu_result = r;
        step();
        fu_done   = 1'b0;
        settle();
        chk({name, "_res_valid"}, 64'(res_valid), 64'd1);
        chk({name, "_res_tag"},   64'(res_tag),   64'(etag));
        chk({name, "_res_data"},  64'(res_data),  64'(r));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        settle();
        chk({name, "_res_clr"},   64'(res_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        disp_valid = 1'b0; disp_tag = '0;
        disp_op0_val = '0; disp_op0_rdy = 1'b0; disp_op0_tag = '0;
        disp_op1_val = '0; disp_op1_rdy = 1'b0; disp_op1_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        fu_idle = 1'b1; fu_done = 1'b0; fu_result = '0;
        res_ready = 1'b0; flush = 1'b0;

        // ---- reset state ----
        step(); step();
        chk("rst_fu_ce",     64'(fu_ce),     64'd0);
        chk("rst_fu_data_0", 64'(fu_data_0), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_tag",   64'(res_tag),   64'd0);
        chk("rst_res_data",  64'(res_data),  64'd0);
        rst = 1'b0;
        settle();
        chk("rst_disp_ready", 64'(disp_ready), 64'd1);

        // ---- basic issue / complete ----
        dispatch(4'd3, 32'd10, 1'b1, 4'd0, 32'd25, 1'b1, 4'd0);
        step();
        disp_valid = 1'b0;
        settle();
        chk("basic_fu_ce", 64'(fu_ce),     64'd1);
        chk("basic_d0",    64'(fu_data_0), 64'd10);
        chk("basic_d1",    64'(fu_data_1), 64'd25);
        step();
        chk("basic_ce_once", 64'(fu_ce),     64'd0);
        chk("basic_d0_zero", 64'(fu_data_0), 64'd0);
        fu_done = 1'b1; fu_result = 32'd15;
        step();
        fu_done = 1'b0;
        settle();
        chk("basic_res_valid", 64'(res_valid), 64'd1);
        chk("basic_res_tag",   64'(res_tag),   64'd3);
        chk("basic_res_data",  64'(res_data),  64'd15);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        settle();
        chk("basic_res_clr", 64'(res_valid), 64'd0);

        // ---- stray fu_done with nothing in flight is ignored ----
        fu_done = 1'b1; fu_result = 32'h77;
        step();
        fu_done = 1'b0;
        settle();
        chk("stray_done", 64'(res_valid), 64'd0);

        // ---- wakeup via CDB two cycles after dispatch ----
        dispatch(4'd1, 32'd4, 1'b1, 4'd0, 32'd0, 1'b0, 4'd7);
        step();
        disp_valid = 1'b0;
        settle();
        chk("wake_wait1", 64'(fu_ce), 64'd0);
        step();
        cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 32'd100;
        settle();
        chk("wake_cdb_cycle", 64'(fu_ce), 64'd0);
        step();
        cdb_valid = 1'b0;
        settle();
        chk("wake_fu_ce", 64'(fu_ce),     64'd1);
        chk("wake_d0",    64'(fu_data_0), 64'd4);
        chk("wake_d1",    64'(fu_data_1), 64'd100);
        complete("wake", 32'h55, 4'd1);

        // ---- dispatch bypass from CDB in the same cycle ----
        dispatch(4'd2, 32'd0, 1'b0, 4'd5, 32'd6, 1'b1, 4'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'd9;
        step();
        disp_valid = 1'b0; cdb_valid = 1'b0;
        settle();
        chk("byp_fu_ce", 64'(fu_ce),     64'd1);
        chk("byp_d0",    64'(fu_data_0), 64'd9);
        chk("byp_d1",    64'(fu_data_1), 64'd6);
        complete("byp", 32'd1, 4'd2);

        // ---- fill all entries, all waiting ----
        dispatch(4'd10, 32'd40, 1'b1, 4'd0, 32'd0,  1'b0, 4'd9);  // entry 0
        step();
        dispatch(4'd11, 32'd0,  1'b0, 4'd8, 32'd21, 1'b1, 4'd0);  // entry 1
        step();
        dispatch(4'd12, 32'd30, 1'b1, 4'd0, 32'd0,  1'b0, 4'd8);  // entry 2
        step();
        dispatch(4'd13, 32'd0,  1'b0, 4'd9, 32'd50, 1'b1, 4'd0);  // entry 3
        settle();
        chk("fill_ready_before_last", 64'(disp_ready), 64'd1);
        step();
        disp_valid = 1'b0;
        settle();
        chk("fill_full",  64'(disp_ready), 64'd0);
        chk("fill_no_ce", 64'(fu_ce),      64'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd8; cdb_data = 32'd77;
        step();
        cdb_valid = 1'b0;
        settle();
        chk("multi_fu_ce",   64'(fu_ce),      64'd1);
        chk("multi_e1_d0",   64'(fu_data_0),  64'd77);
        chk("multi_e1_d1",   64'(fu_data_1),  64'd21);
        chk("multi_full",    64'(disp_ready), 64'd0);
        step();
        chk("multi_freed",   64'(disp_ready), 64'd1);
        chk("multi_busy_ce", 64'(fu_ce),      64'd0);
        fu_done = 1'b1; fu_result = 32'hAB;
        step();
        fu_done = 1'b0;
        settle();
        chk("multi_res_tag", 64'(res_tag), 64'd11);
        // result held back: must stay stable and block further issue
        for (int c = 0; c < 5; c++) begin
            chk("hold_res_valid", 64'(res_valid), 64'd1);
            chk("hold_res_tag",   64'(res_tag),   64'd11);
            chk("hold_res_data",  64'(res_data),  64'hAB);
            chk("hold_fu_ce",     64'(fu_ce),     64'd0);
            step();
        end
        res_ready = 1'b1;
        settle();
        chk("hold_hs_ce", 64'(fu_ce), 64'd0);
        step();
        res_ready = 1'b0;
        settle();
        chk("multi_res_clr", 64'(res_valid), 64'd0);
        chk("multi_e2_ce",   64'(fu_ce),     64'd1);
        chk("multi_e2_d0",   64'(fu_data_0), 64'd30);
        chk("multi_e2_d1",   64'(fu_data_1), 64'd77);
        complete("multi_e2", 32'h12, 4'd12);

        // ---- flush while in flight ----
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'd5;
        step();
        cdb_valid = 1'b0;
        settle();
        chk("fl_e0_ce", 64'(fu_ce),     64'd1);
        chk("fl_e0_d1", 64'(fu_data_1), 64'd5);
        step();
        flush = 1'b1;
        settle();
        chk("fl_ce_blocked", 64'(fu_ce), 64'd0);
        step();
        flush = 1'b0;
        settle();
        chk("fl_ready",    64'(disp_ready), 64'd1);
        chk("fl_e3_gone",  64'(fu_ce),      64'd0);
        fu_done = 1'b1; fu_result = 32'hDEAD;
        step();
        fu_done = 1'b0;
        settle();
        chk("fl_dropped",  64'(res_valid), 64'd0);
        step();
        chk("fl_dropped2", 64'(res_valid), 64'd0);
        chk("fl_idle_ce",  64'(fu_ce),     64'd0);
        dispatch(4'd6, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0);
        step();
        disp_valid = 1'b0;
        settle();
        chk("fl_new_ce", 64'(fu_ce),     64'd1);
        chk("fl_new_d0", 64'(fu_data_0), 64'd1);
        chk("fl_new_d1", 64'(fu_data_1), 64'd2);
        complete("fl_new", 32'd3, 4'd6);

        // ---- reset mid-operation abandons the in-flight op ----
        dispatch(4'd4, 32'd7, 1'b1, 4'd0, 32'd8, 1'b1, 4'd0);
        step();
        disp_valid = 1'b0;
        settle();
        chk("mr_ce", 64'(fu_ce), 64'd1);
        step();
        rst = 1'b1;
        #2;
        chk("mr_rst_ce",  64'(fu_ce),     64'd0);
        chk("mr_rst_res", 64'(res_valid), 64'd0);
        rst = 1'b0;
        fu_done = 1'b1; fu_result = 32'hBEEF;
        step();
        fu_done = 1'b0;
        settle();
        chk("mr_no_res", 64'(res_valid),  64'd0);
        chk("mr_ready",  64'(disp_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
